// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller. Adds two WIDTH-bit operands
// plus a carry-in using a single full-adder cell over WIDTH cycles, LSB first,
// with the running carry held in a flip-flop.
//
// Optional feature macro: SERIAL_ADDER_OVF_EN (adds the signed overflow flag 'ovf').
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset
//   start in   request an addition (accepted only while idle)
//   a, b  in   WIDTH-bit operands, captured on accepted start
//   cin   in   carry-in, captured on accepted start
//   busy  out  high for the WIDTH cycles in which bits are processed
//   done  out  one-cycle pulse, result valid
//   sum   out  WIDTH-bit result, held until the next operation starts shifting
//   cout  out  final carry-out, held with sum
//   ovf   out  (SERIAL_ADDER_OVF_EN only) two's-complement overflow, held with sum
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;
  logic             w_fa_sum;
  logic             w_fa_co;
  logic             w_last;
`ifdef SERIAL_ADDER_OVF_EN
  logic             r_ovf;
`endif

  // Full-adder cell on the operand LSBs and the carry flip-flop
  assign w_fa_sum = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_fa_co  = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));

  // Final bit of the operation is being processed this cycle
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = ST_SHIFT;
      ST_SHIFT: if (w_last) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Datapath and registered handshake outputs. busy/done are registered from
  // the state, so they trail it by one cycle: busy covers the WIDTH shift
  // cycles and done lands WIDTH+1 cycles after the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_busy <= (r_state == ST_SHIFT);
      r_done <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          r_carry <= w_fa_co;
          r_cout  <= w_fa_co;
          r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_cnt   <= r_cnt + CNT_W'(1);
`ifdef SERIAL_ADDER_OVF_EN
          // On the MSB, r_carry is the carry into the MSB
          if (w_last) r_ovf <= r_carry ^ w_fa_co;
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule
